pc_sequencer: RTL and testbench



---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/pc_seq_ctrl.sv | 72 +++++++
 rtl/pc_sequencer.sv | 79 +++++++
 tb/tb_pc_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the pc_sequencer block: FSM state codes,
// PC update selects and default geometry.
package pc_seq_pkg;

    localparam int PC_W_DEFAULT     = 5;
    localparam int RESET_PC_DEFAULT = 0;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t ST_BOOT  = 2'd0;
    localparam pc_state_t ST_RUN   = 2'd1;
    localparam pc_state_t ST_FLUSH = 2'd2;
    localparam pc_state_t ST_HALT  = 2'd3;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the jump unit / decode side and pc_sequencer.
// redirect_count exists only when PC_SEQ_REDIRECT_COUNT_EN is defined.
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
);

    logic            jump_valid;
    logic            jump_taken;
    logic [PC_W-1:0] jump_target;
    logic            link;
    logic [PC_W-1:0] ra_in;
    logic            halt_req;
    logic            resume;
    logic            fetch_ready;

    logic [PC_W-1:0] pc;
    logic            fetch_valid;
    logic [PC_W-1:0] ra_value;
    logic            halted;
`ifdef PC_SEQ_REDIRECT_COUNT_EN
    logic [7:0]      redirect_count;
`endif

    modport master (
        output jump_valid, jump_taken, jump_target, link, ra_in,
               halt_req, resume, fetch_ready,
        input  pc, fetch_valid, ra_value, halted
`ifdef PC_SEQ_REDIRECT_COUNT_EN
        , input redirect_count
`endif
    );

    modport slave (
        input  jump_valid, jump_taken, jump_target, link, ra_in,
               halt_req, resume, fetch_ready,
        output pc, fetch_valid, ra_value, halted
`ifdef PC_SEQ_REDIRECT_COUNT_EN
        , output redirect_count
`endif
    );

endinterface

// File: rtl/pc_seq_ctrl.sv
// Sequencer state machine: BOOT/RUN/FLUSH/HALT, producing the PC update
// select, RA write enable, accepted-redirect strobe and state-decoded outputs.
module pc_seq_ctrl
    import pc_seq_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    jump_valid,
    input  logic    jump_taken,
    input  logic    link,
    input  logic    halt_req,
    input  logic    resume,
    input  logic    fetch_ready,
    output pc_sel_e pc_sel,
    output logic    ra_we,
    output logic    redirect_acc,
    output logic    fetch_valid,
    output logic    halted
);

    pc_state_t state_q, state_d;
    logic      redirect;
    logic      active;

    assign redirect     = jump_valid & jump_taken;
    assign active       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign redirect_acc = active & redirect;
    assign ra_we        = redirect_acc & link;

    // Outputs decode from the state register only, so no input reaches them combinationally.
    assign fetch_valid  = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALT);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_d = state_q;
        pc_sel  = PC_HOLD;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_FLUSH: begin
                if (redirect) begin
                    pc_sel = PC_LOAD;
                end else if (fetch_valid && fetch_ready && !halt_req) begin
                    pc_sel = PC_INC;
                end
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (redirect) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter / return-address stage downstream of the jump unit.
// Optional feature macro: PC_SEQ_REDIRECT_COUNT_EN (saturating redirect counter).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int RESET_PC = RESET_PC_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    pc_sel_e         pc_sel;
    logic            ra_we;
    logic            redirect_acc;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ra_q, ra_d;

    pc_seq_ctrl u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .jump_valid   (bus.jump_valid),
        .jump_taken   (bus.jump_taken),
        .link         (bus.link),
        .halt_req     (bus.halt_req),
        .resume       (bus.resume),
        .fetch_ready  (bus.fetch_ready),
        .pc_sel       (pc_sel),
        .ra_we        (ra_we),
        .redirect_acc (redirect_acc),
        .fetch_valid  (bus.fetch_valid),
        .halted       (bus.halted)
    );

    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PC_LOAD: pc_d = bus.jump_target;
            PC_INC:  pc_d = pc_q + PC_W'(1);
            default: pc_d = pc_q;
        endcase
    end

    assign ra_d = ra_we ? bus.ra_in : ra_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC_V;
            ra_q <= '0;
        end else begin
            pc_q <= pc_d;
            ra_q <= ra_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.ra_value = ra_q;

`ifdef PC_SEQ_REDIRECT_COUNT_EN
    logic [7:0] cnt_q, cnt_d;

    // redirect_acc is never high in HALT, so the count freezes there naturally.
    assign cnt_d = (redirect_acc && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.redirect_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model pushes expected
// post-edge outputs per driven cycle; they are popped and compared after the edge.
module tb_pc_sequencer;

    localparam int PC_W = 5;

    typedef enum int {M_BOOT, M_RUN, M_FLUSH, M_HALT} mstate_e;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            fv;
        logic [PC_W-1:0] ra;
        logic            halted;
        logic [7:0]      cnt;
    } exp_t;

    logic clk;
    logic rst_n;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    exp_t sb_q[$];

    mstate_e         m_st;
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_ra;
    logic [7:0]      m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st  = M_BOOT;
        m_pc  = '0;
        m_ra  = '0;
        m_cnt = '0;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".pc"}, 32'(bus.pc), 32'(e.pc));
        check({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'(e.fv));
        check({tag, ".ra_value"}, 32'(bus.ra_value), 32'(e.ra));
        check({tag, ".halted"}, 32'(bus.halted), 32'(e.halted));
`ifdef PC_SEQ_REDIRECT_COUNT_EN
        check({tag, ".redirect_count"}, 32'(bus.redirect_count), 32'(e.cnt));
`endif
    endtask

    // One clock: drive inputs, advance model and push, then pop/compare after the edge.
    task automatic step(input logic jv, input logic jt, input logic [PC_W-1:0] tgt,
                        input logic lk, input logic [PC_W-1:0] ra,
                        input logic hr, input logic rs, input logic fr);
        logic    redirect;
        mstate_e nxt;
        exp_t    e;
        exp_t    got;
        bus.jump_valid  = jv;
        bus.jump_taken  = jt;
        bus.jump_target = tgt;
        bus.link        = lk;
        bus.ra_in       = ra;
        bus.halt_req    = hr;
        bus.resume      = rs;
        bus.fetch_ready = fr;

        redirect = jv & jt;
        nxt = m_st;
        case (m_st)
            M_BOOT: nxt = M_RUN;
            M_RUN, M_FLUSH: begin
                if (redirect) begin
                    m_pc = tgt;
                    if (lk) m_ra = ra;
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                end else if (m_st == M_RUN && fr && !hr) begin
                    m_pc = m_pc + 1'b1;
                end
                nxt = hr ? M_HALT : (redirect ? M_FLUSH : M_RUN);
            end
            M_HALT: if (rs && !hr) nxt = M_RUN;
            default: nxt = M_BOOT;
        endcase
        m_st = nxt;
        e.pc     = m_pc;
        e.fv     = (m_st == M_RUN);
        e.ra     = m_ra;
        e.halted = (m_st == M_HALT);
        e.cnt    = m_cnt;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'(sb_q.size()), 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_outputs("step", got);
        end
    endtask

    task automatic idle(input logic fr);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, fr);
    endtask

    task automatic jump(input logic [PC_W-1:0] tgt, input logic lk, input logic [PC_W-1:0] ra,
                        input logic hr);
        step(1'b1, 1'b1, tgt, lk, ra, hr, 1'b0, 1'b1);
    endtask

    task automatic run_to(input logic [PC_W-1:0] target);
        for (int i = 0; i < 64 && !(m_pc == target && m_st == M_RUN); i++) begin
            idle(1'b1);
        end
        if (!(m_pc == target && m_st == M_RUN)) begin
            check("run_to_timeout", 32'(m_pc), 32'(target));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t rst_e;
        rst_e = '{pc: '0, fv: 1'b0, ra: '0, halted: 1'b0, cnt: '0};

        rst_n           = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_taken  = 1'b0;
        bus.jump_target = '0;
        bus.link        = 1'b0;
        bus.ra_in       = '0;
        bus.halt_req    = 1'b0;
        bus.resume      = 1'b0;
        bus.fetch_ready = 1'b0;
        model_reset();

        #12;
        check_outputs("reset", rst_e);
        #1 rst_n = 1'b1;

        // BOOT holds pc for one cycle, then sequential fetch with wrap.
        idle(1'b1);
        check("boot_pc", 32'(bus.pc), 32'd0);
        check("boot_fv", 32'(bus.fetch_valid), 32'd1);
        idle(1'b1);
        check("seq_pc1", 32'(bus.pc), 32'd1);
        run_to(5'd31);
        idle(1'b1);
        check("wrap_pc", 32'(bus.pc), 32'd0);

        // Taken jump at pc=3 to 17 with one bubble.
        run_to(5'd3);
        jump(5'd17, 1'b0, 5'd0, 1'b0);
        check("jump_pc", 32'(bus.pc), 32'd17);
        check("flush_fv", 32'(bus.fetch_valid), 32'd0);
        idle(1'b1);
        check("post_flush_pc", 32'(bus.pc), 32'd17);
        idle(1'b1);
        check("post_flush_inc", 32'(bus.pc), 32'd18);

        // Decode backpressure at pc=6.
        run_to(5'd6);
        repeat (3) idle(1'b0);
        check("stall_pc", 32'(bus.pc), 32'd6);
        idle(1'b1);
        check("stall_release", 32'(bus.pc), 32'd7);

        // Jump-and-link, then taken/no-link and not-taken/link must not touch RA.
        run_to(5'd9);
        jump(5'd20, 1'b1, 5'd10, 1'b0);
        check("jal_ra", 32'(bus.ra_value), 32'd10);
        check("jal_pc", 32'(bus.pc), 32'd20);
        idle(1'b1);
        jump(5'd25, 1'b0, 5'd7, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
        check("ra_kept", 32'(bus.ra_value), 32'd10);

        // Redirect together with halt_req, frozen HALT, halt+resume, resume.
        jump(5'd12, 1'b0, 5'd0, 1'b1);
        check("halt_pc", 32'(bus.pc), 32'd12);
        check("halt_flag", 32'(bus.halted), 32'd1);
        step(1'b1, 1'b1, 5'd30, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        check("halt_frozen", 32'(bus.pc), 32'd12);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("resume_fv", 32'(bus.fetch_valid), 32'd1);
        check("resume_pc", 32'(bus.pc), 32'd12);
        idle(1'b1);
        check("resume_inc", 32'(bus.pc), 32'd13);

        // Redirect inside FLUSH, halt_req alone, RA write with halt_req.
        jump(5'd5, 1'b0, 5'd0, 1'b0);
        jump(5'd8, 1'b0, 5'd0, 1'b0);
        check("flush_redirect_pc", 32'(bus.pc), 32'd8);
        idle(1'b1);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        check("halt_no_inc", 32'(bus.pc), 32'd8);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        jump(5'd14, 1'b1, 5'd21, 1'b1);
        check("ra_with_halt", 32'(bus.ra_value), 32'd21);
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

        // Mixed random traffic.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) == 0), 1'($urandom), 5'($urandom), 1'($urandom),
                 5'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
        end
        step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

`ifdef PC_SEQ_REDIRECT_COUNT_EN
        for (int i = 0; i < 300; i++) begin
            jump(5'(i), 1'b0, 5'd0, 1'b0);
        end
        check("redirect_count_sat", 32'(bus.redirect_count), 32'd255);
`endif

        // Asynchronous reset in the middle of FLUSH.
        jump(5'd30, 1'b1, 5'd4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_reset", rst_e);
        @(posedge clk);
        #1;
        check_outputs("reset_held", rst_e);
        #2 rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);
        check("after_reset_pc", 32'(bus.pc), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
